// File: rtl/chunk_serial_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM state encoding and the
// counter-width helper used by the top level.
package chunk_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_t;

    // Ceiling log2 of n, never less than 1 so a single-chunk build still has
    // a one-bit counter.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/chunk_serial_adder_fa_nbit.sv
// W-bit ripple-carry adder slice built from single-bit full-adder cells.
// c_msb is the carry into the top bit, used by the caller for signed overflow.
module fa_nbit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [W:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit; carries ripple from bit 0 upwards.
    for (genvar i = 0; i < W; i++) begin : g_cell
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are consumed CHUNK bits per
// clock through one shared CHUNK-bit slice, behind a start/done handshake.
//
// Handshake: start is sampled only while idle; an accepted start latches a, b,
// cin and sub, after which those inputs may change freely. busy is high while
// the operation runs; done is a single-cycle pulse on the cycle the result
// registers (s, cout, overflow) take their new value. Results hold until the
// next completion. Starts seen while busy are dropped, not queued.
//
// WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH.
module chunk_serial_adder
    import chunk_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = clog2_min1(N);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;

    logic [CHUNK-1:0] slice_s;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] res_next;

    // The shared slice always works on the lowest chunk of the operand
    // shift registers and the running carry.
    fa_nbit #(
        .W(CHUNK)
    ) u_slice (
        .a     (op_a[CHUNK-1:0]),
        .b     (op_b[CHUNK-1:0]),
        .cin   (carry),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    // New result chunk enters at the MSB end so that after N steps the first
    // chunk computed has reached the LSB position.
    always_comb begin
        res_next = (res >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));
    end

    // Control FSM plus datapath registers; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            s        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1, so invert b and force
                        // the initial carry; cin only matters for addition.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> CHUNK;
                    op_b  <= op_b >> CHUNK;
                    carry <= slice_cout;
                    res   <= res_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        // Last chunk: its carries give cout and the signed
                        // overflow (carry into MSB xor carry out of MSB).
                        s        <= res_next;
                        cout     <= slice_cout;
                        overflow <= slice_cout ^ slice_cmsb;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/chunk_serial_adder.md
Name: chunk_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. It processes WIDTH-bit operands CHUNK bits per clock through one shared CHUNK-bit ripple full-adder slice.
- Successor to the fixed-width combinational full-adder chain. It trades latency for area in wide datapaths.
- Sits behind a simple start/done handshake for use by datapath controllers.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
- N (localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b+cin; 1 = a-b (a + ~b + 1); cin is ignored when sub=1.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- s  output  WIDTH  sum/difference; held until the next completion.
- cout  output  1  carry-out. For sub=1, 1 = no borrow (a >= b unsigned).
- overflow  output  1  two's-complement signed overflow of the result.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, s=0, cout=0, overflow=0; chunk counter, operand and carry registers cleared.
- States:
  - IDLE: start=1 at edge T0 latches a, b (inverted if sub), and carry (cin, or 1 if sub), clears the counter, and goes to RUN. busy=1 after T0.
  - RUN: at each edge T1..TN, add the lowest CHUNK bits of the operand shift registers plus the carry register; shift the result chunk into the MSB end of the result shift register; update carry; increment the counter.
  - RUN exit: at edge TN (counter == N-1), write s, cout, overflow; done=1 and busy=0 for the cycle after TN; return to IDLE.
- Latency: result valid N edges after the start edge (4 for the defaults). Back-to-back throughput: one operation per N+1 cycles, because start is accepted at TN+1.
- Overflow: carry into MSB XOR carry out of MSB, taken from the final chunk. The slice exposes the MSB carry-in.
- start while busy: ignored, with no queuing. Inputs a, b, cin and sub may change freely after the start edge.
- done is never asserted without a preceding accepted start. done deasserts on the next edge regardless of start.
- Reset mid-operation: abort immediately to the reset state. No done pulse; s keeps its reset value 0.
- CHUNK == WIDTH: N=1 and the block degenerates to a registered adder with latency 1.
- Arithmetic is modulo 2^WIDTH. The counter width is clog2(N), minimum 1.

Decomposition:
- Shared header/package holds the state encodings (IDLE=2'd0, RUN=2'd1) and a clog2 constant function for the counter width.
- One sub-module, fa_nbit:
  - Purely combinational, parameter W (set to CHUNK), built from single-bit full adders.
  - Ports: a, b, cin, s, cout, plus c_msb, the carry into the top bit, used for overflow.
- The top holds the FSM, counter, shift registers and output registers.

Test Plan (WIDTH=16, CHUNK=4):
- Add with carry-in: sub=0, a=16'h1215, b=16'h3524, cin=1, start pulse.
  - done exactly 4 cycles after the start edge, s=16'h473A, cout=0, overflow=0.
  - busy high for exactly 4 cycles.
- Carry ripple across all chunks: a=16'hFFFF, b=16'h0001, cin=0 -> s=16'h0000, cout=1, overflow=0.
- Subtract with borrow: sub=1, a=16'h0005, b=16'h0007, cin=1 (ignored) -> s=16'hFFFE, cout=0, overflow=0.
- Signed overflow:
  - a=16'h7FFF, b=16'h0001, sub=0, cin=0 -> s=16'h8000, cout=0, overflow=1.
  - sub=1, a=16'h8000, b=16'h0001 -> s=16'h7FFF, cout=1, overflow=1.
- Start while busy: second start with a=16'h0001, b=16'h0001 two cycles into an operation is ignored. The first result completes unchanged and only one done pulse appears; a start at TN+1 is accepted.
- Reset mid-run: rst_n low asynchronously between clock edges during RUN. Outputs go to 0 immediately and no done appears; after release, a new add of 16'h0002 + 16'h0003 yields s=16'h0005.
